// File: rtl/exe_mdu.sv
// Execute stage with EX/MEM output register; single-cycle ALU plus iterative unsigned mul/div.
// Define EXE_MDU_MULDIV_EN to build the multi-cycle multiply/divide unit.
module exe_mdu #(
  parameter int unsigned DATA_W = 16,
  parameter int unsigned REG_AW = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic [2:0]        aluop_i,
  input  logic [2:0]        alusel_i,
  input  logic [DATA_W-1:0] reg0_i,
  input  logic [DATA_W-1:0] reg1_i,
  input  logic [REG_AW-1:0] waddr_i,
  input  logic              we_i,
  output logic              stallreq,
  output logic              we_o,
  output logic [REG_AW-1:0] waddr_o,
  output logic [DATA_W-1:0] wdata_o,
  output logic [1:0]        memrw_o,
  output logic [DATA_W-1:0] memaddr_o,
  output logic [DATA_W-1:0] memdata_o
);
  localparam int unsigned SH_W = $clog2(DATA_W);

  logic [SH_W-1:0]   sh;
  logic [DATA_W-1:0] res;
  logic              we_n;
  logic [1:0]        memrw_n;
  logic [DATA_W-1:0] memaddr_n;
  logic [DATA_W-1:0] memdata_n;

  logic              hold;
  logic              md_done;
  logic [DATA_W-1:0] md_res;
  logic [REG_AW-1:0] md_waddr;
  logic              md_we;

  assign sh = reg1_i[SH_W-1:0];

  always_comb begin
    res       = '0;
    we_n      = we_i;
    memrw_n   = 2'b00;
    memaddr_n = '0;
    memdata_n = '0;
    case (alusel_i)
      3'b001: case (aluop_i)
        3'b000:  res = reg0_i & reg1_i;
        3'b001:  res = reg0_i | reg1_i;
        3'b010:  res = reg0_i ^ reg1_i;
        3'b011:  res = ~reg0_i;
        default: res = '0;
      endcase
      3'b010: case (aluop_i)
        3'b000:  res = reg0_i << sh;
        3'b001:  res = reg0_i >> sh;
        3'b010:  res = DATA_W'($signed(reg0_i) >>> sh);
        default: res = '0;
      endcase
      3'b011: case (aluop_i)
        3'b000:  res = reg0_i + reg1_i;
        3'b001:  res = reg0_i - reg1_i;
        3'b010:  res = DATA_W'($signed(reg0_i) < $signed(reg1_i));
        3'b011:  res = DATA_W'(reg0_i < reg1_i);
        3'b100:  res = DATA_W'(reg0_i != reg1_i);
        default: res = '0;
      endcase
      3'b100: case (aluop_i)
        3'b000: begin
          memrw_n   = 2'b01;
          memaddr_n = reg0_i;
        end
        3'b001: begin
          memrw_n   = 2'b10;
          memaddr_n = reg0_i;
          memdata_n = reg1_i;
          we_n      = 1'b0;
        end
        default: memrw_n = 2'b00;
      endcase
      default: res = '0;
    endcase
  end

`ifdef EXE_MDU_MULDIV_EN
  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t            state, state_n;
  logic [DATA_W-1:0] hi, lo, opnd;
  logic [1:0]        md_op;
  logic [SH_W-1:0]   cnt;
  logic              md_valid, div_zero;
  logic [DATA_W:0]   add_sum, shifted, diff;

  assign md_valid = (alusel_i == 3'b101) && !aluop_i[2];
  assign div_zero = aluop_i[1] && (reg1_i == '0);

  // hi:lo doubles as product (multiply) or remainder:quotient (divide)
  assign add_sum = {1'b0, hi} + {1'b0, (lo[0] ? opnd : {DATA_W{1'b0}})};
  assign shifted = {hi, lo[DATA_W-1]};
  assign diff    = shifted - {1'b0, opnd};

  always_comb begin
    state_n  = state;
    stallreq = 1'b0;
    case (state)
      IDLE: if (md_valid) begin
        stallreq = 1'b1;
        state_n  = div_zero ? DONE : BUSY;
      end
      BUSY: begin
        stallreq = 1'b1;
        if (cnt == SH_W'(DATA_W - 1)) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
    if (flush) state_n = IDLE;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state    <= IDLE;
      hi       <= '0;
      lo       <= '0;
      opnd     <= '0;
      md_op    <= '0;
      cnt      <= '0;
      md_waddr <= '0;
      md_we    <= 1'b0;
    end else begin
      state <= state_n;
      if (state == IDLE && md_valid && !flush) begin
        md_op    <= aluop_i[1:0];
        opnd     <= aluop_i[1] ? reg1_i : reg0_i;
        cnt      <= '0;
        md_waddr <= waddr_i;
        md_we    <= we_i;
        if (div_zero) begin
          hi <= reg0_i;
          lo <= '1;
        end else begin
          hi <= '0;
          lo <= aluop_i[1] ? reg0_i : reg1_i;
        end
      end else if (state == BUSY) begin
        cnt <= cnt + 1'b1;
        if (md_op[1]) begin
          hi <= diff[DATA_W] ? shifted[DATA_W-1:0] : diff[DATA_W-1:0];
          lo <= {lo[DATA_W-2:0], ~diff[DATA_W]};
        end else begin
          hi <= add_sum[DATA_W:1];
          lo <= {add_sum[0], lo[DATA_W-1:1]};
        end
      end
    end
  end

  assign hold    = stallreq;
  assign md_done = (state == DONE);
  assign md_res  = md_op[0] ? hi : lo;
`else
  assign stallreq = 1'b0;
  assign hold     = 1'b0;
  assign md_done  = 1'b0;
  assign md_res   = '0;
  assign md_waddr = '0;
  assign md_we    = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      we_o      <= 1'b0;
      waddr_o   <= '0;
      wdata_o   <= '0;
      memrw_o   <= 2'b00;
      memaddr_o <= '0;
      memdata_o <= '0;
    end else if (flush || hold) begin
      we_o      <= 1'b0;
      waddr_o   <= '0;
      wdata_o   <= '0;
      memrw_o   <= 2'b00;
      memaddr_o <= '0;
      memdata_o <= '0;
    end else if (md_done) begin
      we_o      <= md_we;
      waddr_o   <= md_waddr;
      wdata_o   <= md_res;
      memrw_o   <= 2'b00;
      memaddr_o <= '0;
      memdata_o <= '0;
    end else begin
      we_o      <= we_n;
      waddr_o   <= waddr_i;
      wdata_o   <= res;
      memrw_o   <= memrw_n;
      memaddr_o <= memaddr_n;
      memdata_o <= memdata_n;
    end
  end
endmodule

// File: tb/tb_exe_mdu.sv
// Scoreboard bench for exe_mdu: driver pushes model results, monitor pops on each accepted op.
module tb_exe_mdu;
  localparam int unsigned W = 16;
`ifdef EXE_MDU_MULDIV_EN
  localparam bit MD = 1'b1;
`else
  localparam bit MD = 1'b0;
`endif

  logic          clk, rst, flush;
  logic [2:0]    aluop_i, alusel_i;
  logic [W-1:0]  reg0_i, reg1_i;
  logic [3:0]    waddr_i;
  logic          we_i;
  logic          stallreq, we_o;
  logic [3:0]    waddr_o;
  logic [W-1:0]  wdata_o, memaddr_o, memdata_o;
  logic [1:0]    memrw_o;

  typedef struct packed {
    logic         we;
    logic [3:0]   waddr;
    logic [W-1:0] wdata;
    logic [1:0]   memrw;
    logic [W-1:0] memaddr;
    logic [W-1:0] memdata;
  } out_t;

  out_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  exe_mdu #(.DATA_W(16), .REG_AW(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .aluop_i(aluop_i), .alusel_i(alusel_i),
    .reg0_i(reg0_i), .reg1_i(reg1_i),
    .waddr_i(waddr_i), .we_i(we_i),
    .stallreq(stallreq),
    .we_o(we_o), .waddr_o(waddr_o), .wdata_o(wdata_o),
    .memrw_o(memrw_o), .memaddr_o(memaddr_o), .memdata_o(memdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic out_t model(input logic [2:0] sel, input logic [2:0] op,
                                 input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic we, input logic [3:0] wa);
    out_t         r;
    logic [2*W-1:0] p;
    logic [W-1:0] ones;
    int unsigned  s;
    ones = '1;
    r = '0;
    r.we = we;
    r.waddr = wa;
    s = int'(b) % W;
    case (sel)
      3'd1: case (op)
        3'd0: r.wdata = a & b;
        3'd1: r.wdata = a | b;
        3'd2: r.wdata = a ^ b;
        3'd3: r.wdata = ~a;
        default: r.wdata = '0;
      endcase
      3'd2: case (op)
        3'd0: r.wdata = a << s;
        3'd1: r.wdata = a >> s;
        3'd2: r.wdata = (a >> s) | (a[W-1] ? ~(ones >> s) : '0);
        default: r.wdata = '0;
      endcase
      3'd3: case (op)
        3'd0: r.wdata = a + b;
        3'd1: r.wdata = a - b;
        3'd2: r.wdata = ($signed(a) < $signed(b)) ? 16'd1 : 16'd0;
        3'd3: r.wdata = (a < b) ? 16'd1 : 16'd0;
        3'd4: r.wdata = (a != b) ? 16'd1 : 16'd0;
        default: r.wdata = '0;
      endcase
      3'd4: case (op)
        3'd0: begin r.memrw = 2'b01; r.memaddr = a; end
        3'd1: begin r.memrw = 2'b10; r.memaddr = a; r.memdata = b; r.we = 1'b0; end
        default: r.memrw = 2'b00;
      endcase
      3'd5: if (MD) begin
        p = 32'(a) * 32'(b);
        case (op)
          3'd0: r.wdata = p[W-1:0];
          3'd1: r.wdata = p[2*W-1:W];
          3'd2: r.wdata = (b == 0) ? ones : a / b;
          3'd3: r.wdata = (b == 0) ? a : a % b;
          default: r.wdata = '0;
        endcase
      end
      default: r.wdata = '0;
    endcase
    return r;
  endfunction

  function automatic int exp_stall(input logic [2:0] sel, input logic [2:0] op, input logic [W-1:0] b);
    if (MD && sel == 3'd5 && op < 3'd4) return (op >= 3'd2 && b == 0) ? 1 : int'(W) + 1;
    return 0;
  endfunction

  task automatic issue(input logic [2:0] sel, input logic [2:0] op,
                       input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic we, input logic [3:0] wa,
                       input bit use_k, input logic [W-1:0] k);
    out_t e;
    int   stalls;
    bit   ok;
    @(posedge clk); #1;
    flush = 1'b0; alusel_i = sel; aluop_i = op; reg0_i = a; reg1_i = b; we_i = we; waddr_i = wa;
    e = model(sel, op, a, b, we, wa);
    if (use_k) e.wdata = k;
    sb.push_back(e);
    stalls = 0;
    ok = 1'b0;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (!stallreq) begin ok = 1'b1; break; end
      stalls++;
      @(posedge clk);
    end
    n_cmp++;
    if (!ok || stalls != exp_stall(sel, op, b)) begin
      n_bad++;
      $display("FAIL stall_len sel=%0d op=%0d: got %0d cycles (accepted=%0b), required %0d",
               sel, op, stalls, ok, exp_stall(sel, op, b));
    end
  endtask

  function automatic logic [W-1:0] pick();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return '1;
      2: return 16'h8000;
      3: return 16'h0001;
      default: return W'($urandom);
    endcase
  endfunction

  // Monitor: the value loaded at each edge is decided by the inputs seen just before it
  initial begin
    out_t  got, exp_cur;
    bit    have_exp;
    string exp_name;
    have_exp = 1'b0;
    exp_cur = '0;
    exp_name = "";
    forever begin
      @(negedge clk);
      got = {we_o, waddr_o, wdata_o, memrw_o, memaddr_o, memdata_o};
      if (!rst) begin
        n_cmp++;
        if (got !== '0) begin
          n_bad++;
          $display("FAIL reset_state: got wdata=%h we=%b memrw=%b, required all zero", wdata_o, we_o, memrw_o);
        end
        have_exp = 1'b0;
      end else begin
        if (have_exp) begin
          n_cmp++;
          if (got !== exp_cur) begin
            n_bad++;
            $display("FAIL %s: got we=%b waddr=%h wdata=%h memrw=%b memaddr=%h memdata=%h, required we=%b waddr=%h wdata=%h memrw=%b memaddr=%h memdata=%h",
                     exp_name, got.we, got.waddr, got.wdata, got.memrw, got.memaddr, got.memdata,
                     exp_cur.we, exp_cur.waddr, exp_cur.wdata, exp_cur.memrw, exp_cur.memaddr, exp_cur.memdata);
          end
        end
        if (flush || stallreq) begin
          exp_cur = '0; exp_name = "bubble"; have_exp = 1'b1;
        end else if (sb.size() > 0) begin
          exp_cur = sb.pop_front(); exp_name = "result"; have_exp = 1'b1;
        end else begin
          have_exp = 1'b0;
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; flush = 1'b0; alusel_i = '0; aluop_i = '0;
    reg0_i = '0; reg1_i = '0; waddr_i = '0; we_i = 1'b0;
    #2 rst = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;

    issue(3'd3, 3'd0, 16'd8, 16'd1, 1'b1, 4'd1, 1'b1, 16'd9);
    issue(3'd3, 3'd1, 16'd8, 16'd1, 1'b1, 4'd2, 1'b1, 16'd7);
    issue(3'd3, 3'd2, 16'hFFFF, 16'd1, 1'b1, 4'd3, 1'b1, 16'd1);
    issue(3'd2, 3'd2, 16'h807F, 16'd4, 1'b1, 4'd4, 1'b1, 16'hF807);
    issue(3'd2, 3'd1, 16'h807F, 16'd4, 1'b1, 4'd5, 1'b1, 16'h0807);
    issue(3'd5, 3'd0, 16'd300, 16'd5, 1'b1, 4'd6, MD, 16'h05DC);
    issue(3'd5, 3'd1, 16'h8000, 16'd4, 1'b1, 4'd7, MD, 16'h0002);
    issue(3'd5, 3'd2, 16'd100, 16'd7, 1'b1, 4'd8, MD, 16'd14);
    issue(3'd5, 3'd3, 16'd100, 16'd7, 1'b1, 4'd9, MD, 16'd2);
    issue(3'd5, 3'd2, 16'h1234, 16'd0, 1'b1, 4'd10, MD, 16'hFFFF);
    issue(3'd4, 3'd1, 16'h0040, 16'hBEEF, 1'b1, 4'd11, 1'b0, '0);
    issue(3'd5, 3'd2, 16'h1234, 16'd3, 1'b1, 4'd12, 1'b0, '0);

    // Flush during BUSY cycle 5 of a multiply
    @(posedge clk); #1;
    alusel_i = 3'd5; aluop_i = 3'd0; reg0_i = 16'd300; reg1_i = 16'd5; we_i = 1'b1; waddr_i = 4'd13;
    repeat (5) @(posedge clk);
    #1 flush = 1'b1; alusel_i = 3'd0; aluop_i = 3'd0;
    @(negedge clk);
    n_cmp++;
    if (stallreq !== MD) begin
      n_bad++;
      $display("FAIL stall_before_flush: got %b, required %b", stallreq, MD);
    end
    issue(3'd3, 3'd0, 16'd2, 16'd3, 1'b1, 4'd14, 1'b1, 16'd5);

    // Asynchronous reset clears a freshly written result
    issue(3'd3, 3'd0, 16'd8, 16'd1, 1'b1, 4'd1, 1'b1, 16'd9);
    @(posedge clk); #1;
    n_cmp++;
    if (wdata_o !== 16'd9) begin
      n_bad++;
      $display("FAIL pre_reset: got %h, required 0009", wdata_o);
    end
    rst = 1'b0; alusel_i = 3'd0;
    #1;
    n_cmp++;
    if ({we_o, waddr_o, wdata_o} !== '0) begin
      n_bad++;
      $display("FAIL async_reset: got we=%b waddr=%h wdata=%h, required all zero", we_o, waddr_o, wdata_o);
    end
    @(posedge clk); #1 rst = 1'b1;

    // Reset in the middle of a divide, then normal traffic
    @(posedge clk); #1;
    alusel_i = 3'd5; aluop_i = 3'd2; reg0_i = 16'hABCD; reg1_i = 16'd9; we_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0; alusel_i = 3'd0;
    @(posedge clk); #1 rst = 1'b1;
    issue(3'd3, 3'd0, 16'd2, 16'd3, 1'b1, 4'd15, 1'b1, 16'd5);

    for (int n = 0; n < 200; n++) begin
      logic [2:0] sel;
      logic [2:0] op;
      sel = ($urandom_range(0, 3) == 0) ? 3'd5 : 3'($urandom_range(0, 7));
      op  = (sel == 3'd5 && $urandom_range(0, 4) != 0) ? 3'($urandom_range(0, 3)) : 3'($urandom_range(0, 7));
      issue(sel, op, pick(), pick(), 1'($urandom), 4'($urandom), 1'b0, '0);
    end

    issue(3'd0, 3'd0, '0, '0, 1'b0, 4'd0, 1'b0, '0);
    repeat (3) @(negedge clk);
    n_cmp++;
    if (sb.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d pending, required 0", sb.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
